// File: rtl/reg_file_sb.sv
// Register file with an ALU write port, a load-return port tracked by a single-entry scoreboard,
// per-read-port hazard flags and a one-cycle strobe on writes to the OUT register.
// Optional same-cycle read forwarding: define REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
  parameter int unsigned DW       = 8,
  parameter int unsigned PW       = 3,
  parameter int unsigned FLAG_IDX = 6,
  parameter int unsigned OUT_IDX  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          ld_issue,
  input  logic [PW-1:0] ld_addr,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  input  logic          par,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          hazA,
  output logic          hazB,
  output logic          ld_busy,
  output logic [DW-1:0] out_reg,
  output logic          out_valid
);

  localparam int unsigned Depth    = 2 ** PW;
  localparam logic [PW-1:0] FlagAddr = PW'(FLAG_IDX);
  localparam logic [PW-1:0] OutAddr  = PW'(OUT_IDX);

  typedef enum logic [0:0] {StIdle, StPend} ld_state_e;

  ld_state_e     ld_state_q, ld_state_d;
  logic [PW-1:0] pend_addr_q, pend_addr_d;
  logic          cancel_q, cancel_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] core_q [Depth];
  logic [DW-1:0] core_d [Depth];

  logic          pend;
  logic          w_hits_pend;
  logic          ld_commit;

  assign pend        = (ld_state_q == StPend);
  assign w_hits_pend = wr_en & (wr_addr == pend_addr_q);
  // A port-W write to the same address in the same cycle supersedes the returning load.
  assign ld_commit   = pend & ld_valid & ~cancel_q & ~w_hits_pend;

  // Register array next state: load first, ALU write last so W wins on collision.
  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      core_d[i] = core_q[i];
    end
    if (ld_commit) begin
      core_d[pend_addr_q] = ld_data;
    end
    if (wr_en) begin
      core_d[wr_addr] = wr_data;
    end
  end

  // Load scoreboard.
  always_comb begin
    ld_state_d  = ld_state_q;
    pend_addr_d = pend_addr_q;
    cancel_d    = cancel_q;
    unique case (ld_state_q)
      StIdle: begin
        if (ld_issue) begin
          ld_state_d  = StPend;
          pend_addr_d = ld_addr;
          cancel_d    = 1'b0;
        end
      end
      StPend: begin
        if (ld_valid) begin
          cancel_d = 1'b0;
          if (ld_issue) begin
            pend_addr_d = ld_addr;
          end else begin
            ld_state_d = StIdle;
          end
        end else if (w_hits_pend) begin
          // WAW: the ALU value is younger, so the eventual load return is dropped.
          cancel_d = 1'b1;
        end
      end
      default: begin
        ld_state_d = StIdle;
      end
    endcase
  end

  assign out_valid_d = (wr_en & (wr_addr == OutAddr)) | (ld_commit & (pend_addr_q == OutAddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q  <= StIdle;
      pend_addr_q <= '0;
      cancel_q    <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        core_q[i] <= '0;
      end
    end else begin
      ld_state_q  <= ld_state_d;
      pend_addr_q <= pend_addr_d;
      cancel_q    <= cancel_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < Depth; i++) begin
        core_q[i] <= core_d[i];
      end
    end
  end

  // Read ports.
  logic [PW-1:0] rd_addr [2];
  logic [DW-1:0] rd_dat  [2];
  logic          rd_haz  [2];

  assign rd_addr[0] = rd_addrA;
  assign rd_addr[1] = rd_addrB;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_dat[p] = core_q[rd_addr[p]];
`ifdef REG_FILE_SB_BYPASS_EN
      if (wr_en && (wr_addr == rd_addr[p])) begin
        rd_dat[p] = wr_data;
      end else if (ld_commit && (pend_addr_q == rd_addr[p])) begin
        rd_dat[p] = ld_data;
      end
`endif
      if (rd_addr[p] == FlagAddr) begin
        rd_dat[p] = {{(DW-1){1'b0}}, par};
      end
      rd_haz[p] = pend & ~cancel_q & (rd_addr[p] == pend_addr_q) & (rd_addr[p] != FlagAddr);
`ifdef REG_FILE_SB_BYPASS_EN
      // The returning value is forwarded, so no stall is needed on the return cycle.
      rd_haz[p] = rd_haz[p] & ~ld_valid;
`endif
    end
  end

  assign datA_out  = rd_dat[0];
  assign datB_out  = rd_dat[1];
  assign hazA      = rd_haz[0];
  assign hazB      = rd_haz[1];
  assign ld_busy   = pend;
  assign out_reg   = core_q[OutAddr];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized bench for reg_file_sb against an array/flag reference model, plus directed scenarios.
module tb_reg_file_sb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, ld_issue, ld_valid, par;
  logic [2:0] wr_addr, ld_addr, rd_addrA, rd_addrB;
  logic [7:0] wr_data, ld_data;
  logic [7:0] datA_out, datB_out, out_reg;
  logic       hazA, hazB, ld_busy, out_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0] m_mem [8];
  bit         m_busy, m_cancel, m_ov;
  logic [2:0] m_pend;

  always #5 clk = ~clk;

  reg_file_sb #(.DW(8), .PW(3), .FLAG_IDX(6), .OUT_IDX(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ld_issue (ld_issue),
    .ld_addr  (ld_addr),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .rd_addrA (rd_addrA),
    .rd_addrB (rd_addrB),
    .par      (par),
    .datA_out (datA_out),
    .datB_out (datB_out),
    .hazA     (hazA),
    .hazB     (hazB),
    .ld_busy  (ld_busy),
    .out_reg  (out_reg),
    .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_busy   = 0;
    m_cancel = 0;
    m_ov     = 0;
    m_pend   = 3'd0;
  endtask

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (a == 3'd6) return {7'd0, par};
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
    if (m_busy && ld_valid && !m_cancel && m_pend == a) return ld_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_haz(input logic [2:0] a);
    logic h;
    h = m_busy && !m_cancel && (a == m_pend) && (a != 3'd6);
`ifdef REG_FILE_SB_BYPASS_EN
    if (ld_valid) h = 1'b0;
`endif
    return h;
  endfunction

  task automatic compare();
    check("datA", datA_out, exp_rd(rd_addrA));
    check("datB", datB_out, exp_rd(rd_addrB));
    check("hazA", hazA, exp_haz(rd_addrA));
    check("hazB", hazB, exp_haz(rd_addrB));
    check("ld_busy", ld_busy, m_busy);
    check("out_reg", out_reg, m_mem[7]);
    check("out_valid", out_valid, m_ov);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit l_commit;
    l_commit = m_busy && ld_valid && !m_cancel && !(wr_en && wr_addr == m_pend);
    m_ov = (wr_en && wr_addr == 3'd7) || (l_commit && m_pend == 3'd7);
    if (l_commit) m_mem[m_pend] = ld_data;
    if (wr_en) m_mem[wr_addr] = wr_data;
    if (!m_busy) begin
      if (ld_issue) begin
        m_busy = 1; m_pend = ld_addr; m_cancel = 0;
      end
    end else if (ld_valid) begin
      m_cancel = 0;
      if (ld_issue) m_pend = ld_addr;
      else m_busy = 0;
    end else if (wr_en && wr_addr == m_pend) begin
      m_cancel = 1;
    end
  endtask

  task automatic settle();
    #2;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; ld_issue = 0; ld_valid = 0;
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    ld_issue = 0; ld_addr = 0; ld_valid = 0; ld_data = 0;
    rd_addrA = 0; rd_addrB = 0; par = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    settle();
    check("rst_busy", ld_busy, 1'b0);
    check("rst_out", out_reg, 8'h00);
    tick();

    // Reset clears a freshly written register asynchronously.
    wr_en = 1; wr_addr = 3'd2; wr_data = 8'h5A; rd_addrA = 3'd2;
    settle(); tick();
    idle_inputs();
    settle();
    check("r2_written", datA_out, 8'h5A);
    reset_mid();
    check("rst_r2", datA_out, 8'h00);
    check("rst_out_reg", out_reg, 8'h00);
    check("rst_ld_busy", ld_busy, 1'b0);
    settle(); tick();

    // Flag overlay hides the stored value.
    wr_en = 1; wr_addr = 3'd6; wr_data = 8'hFF;
    settle(); tick();
    idle_inputs(); par = 1; rd_addrB = 3'd6;
    settle();
    check("flag_par1", datB_out, 8'h01);
    tick();
    par = 0;
    settle();
    check("flag_par0", datB_out, 8'h00);
    tick();

    // Load to r3 with hazard, then return.
    ld_issue = 1; ld_addr = 3'd3;
    settle(); tick();
    idle_inputs(); rd_addrA = 3'd3; rd_addrB = 3'd4;
    settle();
    check("ld3_busy", ld_busy, 1'b1);
    check("ld3_hazA", hazA, 1'b1);
    check("ld3_hazB", hazB, 1'b0);
    tick();
    settle(); tick();
    ld_valid = 1; ld_data = 8'h3C;
    settle(); tick();
    idle_inputs();
    settle();
    check("ld3_data", datA_out, 8'h3C);
    check("ld3_haz_clr", hazA, 1'b0);
    check("ld3_idle", ld_busy, 1'b0);
    tick();

    // WAW cancel on r5.
    ld_issue = 1; ld_addr = 3'd5;
    settle(); tick();
    idle_inputs(); wr_en = 1; wr_addr = 3'd5; wr_data = 8'h11;
    settle(); tick();
    idle_inputs(); rd_addrA = 3'd5;
    settle();
    check("waw_haz", hazA, 1'b0);
    tick();
    ld_valid = 1; ld_data = 8'h99;
    settle(); tick();
    idle_inputs();
    settle();
    check("waw_keep", datA_out, 8'h11);
    check("waw_retire", ld_busy, 1'b0);
    tick();

    // OUT strobe, then a cancelled load to r7.
    wr_en = 1; wr_addr = 3'd7; wr_data = 8'hA5;
    settle(); tick();
    idle_inputs();
    settle();
    check("out_val", out_reg, 8'hA5);
    check("out_pulse", out_valid, 1'b1);
    tick();
    settle();
    check("out_pulse_end", out_valid, 1'b0);
    tick();
    ld_issue = 1; ld_addr = 3'd7;
    settle(); tick();
    idle_inputs(); wr_en = 1; wr_addr = 3'd7; wr_data = 8'h42;
    settle(); tick();
    idle_inputs();
    settle(); tick();
    ld_valid = 1; ld_data = 8'h77;
    settle(); tick();
    idle_inputs();
    settle();
    check("out_nopulse", out_valid, 1'b0);
    check("out_kept", out_reg, 8'h42);
    tick();

    // Back-to-back loads r1 then r2.
    ld_issue = 1; ld_addr = 3'd1;
    settle(); tick();
    ld_issue = 1; ld_addr = 3'd2; ld_valid = 1; ld_data = 8'hB1; rd_addrA = 3'd1;
    settle();
`ifdef REG_FILE_SB_BYPASS_EN
    check("b2b_fwd", datA_out, 8'hB1);
`endif
    tick();
    idle_inputs(); rd_addrA = 3'd1; rd_addrB = 3'd2;
    settle();
    check("b2b_r1", datA_out, 8'hB1);
    check("b2b_busy", ld_busy, 1'b1);
    check("b2b_hazA", hazA, 1'b0);
    check("b2b_hazB", hazB, 1'b1);
    tick();
    ld_valid = 1; ld_data = 8'hB2;
    settle(); tick();
    idle_inputs();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom);
      ld_issue = ($urandom_range(0, 3) == 0);
      ld_addr  = 3'($urandom_range(0, 7));
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_data  = 8'($urandom);
      rd_addrA = 3'($urandom_range(0, 7));
      rd_addrB = m_busy && $urandom_range(0, 1) ? m_pend : 3'($urandom_range(0, 7));
      par      = 1'($urandom);
      if ($urandom_range(0, 149) == 0) reset_mid();
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
